multicycle_controller: RTL and testbench

Parametrised multi-cycle control unit for the accumulator processor. It fetches instruction words over a ready/valid memory port that tolerates wait states, decodes an internal 4-bit instruction class, and sequences the accumulator/register-bank datapath. It supports immediate, direct load/store, unconditional and zero-conditional jumps, and halt. It sits between the unified program/data memory and the datapath (ALU, accumulator, register bank).

---
 rtl/multicycle_controller.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle control unit for the accumulator processor
//
// Fetches instruction words over a ready/valid memory port (wait states
// allowed), decodes a 4-bit instruction class and sequences the
// accumulator / register-bank datapath.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_run                 permits a new fetch (sampled in FETCH only)
//   i_mem_rdata/ready     memory read data / request completion
//   i_zero_flag           accumulator == 0 from datapath
//   o_mem_req/we/addr     memory request, write enable, address
//   o_alu_sel             ALU operation
//   o_acc_load/acc_src    accumulator capture and source select
//   o_reg_sel/load/src    bank register index, capture, source select
//   o_bank_to_mem         bank register reg_sel drives memory write data
//   o_pc                  program counter (debug)
//   o_halted              in HALT state
//   o_illegal_op          pulse on undefined class
//   o_instr_done          pulse on final cycle of each instruction
module multicycle_controller #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int REG_W  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    input  logic              i_zero_flag,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [2:0]        o_alu_sel,
    output logic              o_acc_load,
    output logic              o_acc_src,
    output logic [REG_W-1:0]  o_reg_sel,
    output logic              o_reg_load,
    output logic              o_reg_src,
    output logic              o_bank_to_mem,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted,
    output logic              o_illegal_op,
    output logic              o_instr_done
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, OPND, ADDR, MEMRD, MEMWR, HALT
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_pc, w_pc_next;
    logic [DATA_W-1:0]   r_ir, w_ir_next;
    logic [ADDR_W-1:0]   r_ar, w_ar_next;

    logic [3:0]          w_class;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_unused_ok;

    assign w_class  = r_ir[DATA_W-1 -: 4];
    assign w_pc_inc = r_pc + PC_ONE;   // wraps silently at 2**ADDR_W
    assign w_addr   = i_mem_rdata[ADDR_W-1:0];
    assign o_pc     = r_pc;
    assign o_reg_sel = r_ir[REG_W-1:0];
    assign w_unused_ok = &{1'b0, r_ir};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_ar    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
            r_ar    <= w_ar_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_ir_next     = r_ir;
        w_ar_next     = r_ar;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = r_pc;
        o_alu_sel     = 3'd0;
        o_acc_load    = 1'b0;
        o_acc_src     = 1'b0;
        o_reg_load    = 1'b0;
        o_reg_src     = 1'b0;
        o_bank_to_mem = 1'b0;
        o_halted      = 1'b0;
        o_illegal_op  = 1'b0;
        o_instr_done  = 1'b0;

        case (r_state)
            FETCH: begin
                if (i_run) begin
                    o_mem_req = 1'b1;
                    if (i_mem_ready) begin
                        w_ir_next    = i_mem_rdata;
                        w_pc_next    = w_pc_inc;
                        w_state_next = DECODE;
                    end
                end
            end
            DECODE: begin
                case (w_class)
                    4'h4:                   w_state_next = OPND;
                    4'h5, 4'h6, 4'h7, 4'h8: w_state_next = ADDR;
                    4'hF:                   w_state_next = HALT;
                    default:                w_state_next = EXEC;
                endcase
            end
            EXEC: begin
                o_instr_done = 1'b1;
                w_state_next = FETCH;
                case (w_class)
                    4'h1: begin
                        o_alu_sel  = r_ir[2:0];
                        o_acc_load = 1'b1;
                    end
                    4'h2: o_reg_load = 1'b1;
                    4'h3: begin
                        o_acc_load = 1'b1;
                        o_acc_src  = 1'b1;
                    end
                    4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: o_illegal_op = 1'b1;
                    default: ;
                endcase
            end
            OPND: begin
                o_mem_req = 1'b1;
                o_reg_src = 1'b1;
                if (i_mem_ready) begin
                    o_reg_load   = 1'b1;
                    o_instr_done = 1'b1;
                    w_pc_next    = w_pc_inc;
                    w_state_next = FETCH;
                end
            end
            ADDR: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    w_pc_next = w_pc_inc;
                    w_ar_next = w_addr;
                    case (w_class)
                        4'h5: w_state_next = MEMRD;
                        4'h6: w_state_next = MEMWR;
                        4'h7: begin
                            w_pc_next    = w_addr;
                            o_instr_done = 1'b1;
                            w_state_next = FETCH;
                        end
                        default: begin
                            // Only JZ reaches here; the taken branch replaces the increment.
                            if (i_zero_flag) w_pc_next = w_addr;
                            o_instr_done = 1'b1;
                            w_state_next = FETCH;
                        end
                    endcase
                end
            end
            MEMRD: begin
                o_mem_req  = 1'b1;
                o_mem_addr = r_ar;
                o_reg_src  = 1'b1;
                if (i_mem_ready) begin
                    o_reg_load   = 1'b1;
                    o_instr_done = 1'b1;
                    w_state_next = FETCH;
                end
            end
            MEMWR: begin
                o_mem_req     = 1'b1;
                o_mem_we      = 1'b1;
                o_bank_to_mem = 1'b1;
                o_mem_addr    = r_ar;
                if (i_mem_ready) begin
                    o_instr_done = 1'b1;
                    w_state_next = FETCH;
                end
            end
            HALT: o_halted = 1'b1;
            default: w_state_next = FETCH;
        endcase

        // Reset kills any in-flight request in the same cycle rather than
        // waiting for the registered state to settle.
        if (reset) begin
            o_mem_req     = 1'b0;
            o_mem_we      = 1'b0;
            o_mem_addr    = RESET_PC;
            o_alu_sel     = 3'd0;
            o_acc_load    = 1'b0;
            o_acc_src     = 1'b0;
            o_reg_load    = 1'b0;
            o_reg_src     = 1'b0;
            o_bank_to_mem = 1'b0;
            o_halted      = 1'b0;
            o_illegal_op  = 1'b0;
            o_instr_done  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_run = 1'b1;
    logic [7:0] i_mem_rdata = 8'h00;
    logic       i_mem_ready = 1'b0;
    logic       i_zero_flag = 1'b0;
    logic       o_mem_req, o_mem_we, o_acc_load, o_acc_src, o_reg_load, o_reg_src;
    logic       o_bank_to_mem, o_halted, o_illegal_op, o_instr_done;
    logic [7:0] o_mem_addr, o_pc;
    logic [2:0] o_alu_sel;
    logic [1:0] o_reg_sel;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_mem_rdata(i_mem_rdata),
        .i_mem_ready(i_mem_ready), .i_zero_flag(i_zero_flag),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_alu_sel(o_alu_sel), .o_acc_load(o_acc_load), .o_acc_src(o_acc_src),
        .o_reg_sel(o_reg_sel), .o_reg_load(o_reg_load), .o_reg_src(o_reg_src),
        .o_bank_to_mem(o_bank_to_mem), .o_pc(o_pc), .o_halted(o_halted),
        .o_illegal_op(o_illegal_op), .o_instr_done(o_instr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          len;
        logic [12:0] strb;
        logic [7:0]  pc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [256];
    int         total = 0;
    int         bad = 0;
    int         wait_n = 0;
    int         wcnt = 0;
    int         wr_cnt = 0;
    logic [7:0] wr_addr = 8'h00;
    int         cyc = 0;
    bit         mon_en = 0;
    bit         pend_pc = 0;
    logic [7:0] pend_val = 8'h00;
    string      pend_tag = "";
    int         hold_cnt = 0;
    int         ill_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] mk(input bit al, input bit as, input bit rl, input bit rs,
                                       input bit we, input bit bm, input bit il,
                                       input logic [2:0] alu, input logic [1:0] rsel);
        return {al, as, rl, rs, we, bm, il, alu, rsel};
    endfunction

    task automatic push(input string tag, input int len, input logic [12:0] strb, input logic [7:0] pc);
        exp_t e;
        e.tag = tag; e.len = len; e.strb = strb; e.pc = pc;
        sb.push_back(e);
    endtask

    // Memory responder: wait_n stall cycles before each access completes.
    always @(negedge clk) begin
        i_zero_flag = (o_pc == 8'h15);
        i_mem_rdata = mem[o_mem_addr];
        if (!o_mem_req) begin
            wcnt = 0;
            i_mem_ready = 1'b0;
        end else begin
            i_mem_ready = (wcnt >= wait_n);
            if (i_mem_ready) wcnt = 0;
            else wcnt++;
            if (i_mem_ready && o_mem_we) begin
                wr_cnt++;
                wr_addr = o_mem_addr;
            end
        end
    end

    // Monitor: pops the scoreboard on every instr_done pulse.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (pend_pc) begin
            check({pend_tag, "_pc"}, o_pc, pend_val);
            pend_pc = 0;
        end
        if (reset) cyc = 0;
        else begin
            cyc++;
            if (o_mem_we && o_bank_to_mem && o_mem_addr == 8'h80) hold_cnt++;
            if (o_illegal_op) ill_cnt++;
            if (o_instr_done && mon_en) begin
                if (sb.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    check({e.tag, "_len"}, cyc, e.len);
                    check({e.tag, "_strb"}, {o_acc_load, o_acc_src, o_reg_load, o_reg_src, o_mem_we,
                                             o_bank_to_mem, o_illegal_op, o_alu_sel, o_reg_sel}, e.strb);
                    pend_pc = 1; pend_val = e.pc; pend_tag = e.tag;
                end
            end
            if (o_instr_done) cyc = 0;
        end
    end

    task automatic start_prog(input int wn);
        reset = 1'b1;
        wait_n = wn;
        hold_cnt = 0; ill_cnt = 0; wr_cnt = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(negedge clk);
            #2;
            n++;
        end
        check({tag, "_drain_left"}, sb.size(), 0);
        @(negedge clk);
        #2;
        mon_en = 0;
        sb.delete();
    endtask

    initial begin
        int n;
        int req_seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", o_mem_req, 0);
        check("rst_mem_addr", o_mem_addr, 8'h00);
        check("rst_pc", o_pc, 8'h00);
        check("rst_halted", o_halted, 0);
        check("rst_done", o_instr_done, 0);
        check("rst_strobes", {o_acc_load, o_reg_load, o_mem_we, o_bank_to_mem, o_illegal_op}, 0);

        // Program A: no wait states, every class, pc wrap
        mem[8'h00] = 8'h41; mem[8'h01] = 8'h5A;
        mem[8'h02] = 8'h13;
        mem[8'h03] = 8'h22;
        mem[8'h04] = 8'h31;
        mem[8'h05] = 8'hB0;
        mem[8'h06] = 8'h52; mem[8'h07] = 8'h90;
        mem[8'h08] = 8'h70; mem[8'h09] = 8'hFF;
        mem[8'hFF] = 8'h00;
        push("ldi",  3, mk(0,0,1,1,0,0,0,3'd0,2'd1), 8'h02);
        push("alu",  3, mk(1,0,0,0,0,0,0,3'd3,2'd3), 8'h03);
        push("mova", 3, mk(0,0,1,0,0,0,0,3'd0,2'd2), 8'h04);
        push("movr", 3, mk(1,1,0,0,0,0,0,3'd0,2'd1), 8'h05);
        push("ill",  3, mk(0,0,0,0,0,0,1,3'd0,2'd0), 8'h06);
        push("ld",   4, mk(0,0,1,1,0,0,0,3'd0,2'd2), 8'h08);
        push("jmp",  3, mk(0,0,0,0,0,0,0,3'd0,2'd0), 8'hFF);
        push("nopwrap", 3, mk(0,0,0,0,0,0,0,3'd0,2'd0), 8'h00);
        push("ldi2", 3, mk(0,0,1,1,0,0,0,3'd0,2'd1), 8'h02);
        mon_en = 1;
        start_prog(0);
        drain("progA");
        check("ill_pulse_cnt", ill_cnt, 1);

        // Program B: two wait states per access, ST, JZ both ways, HLT
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h70; mem[8'h01] = 8'h10;
        mem[8'h10] = 8'h62; mem[8'h11] = 8'h80;
        mem[8'h12] = 8'h80; mem[8'h13] = 8'h30;
        mem[8'h14] = 8'h80; mem[8'h15] = 8'h30;
        mem[8'h30] = 8'hF0;
        push("jmpw", 7,  mk(0,0,0,0,0,0,0,3'd0,2'd0), 8'h10);
        push("st",   10, mk(0,0,0,0,1,1,0,3'd0,2'd2), 8'h12);
        push("jz_nt", 7, mk(0,0,0,0,0,0,0,3'd0,2'd0), 8'h14);
        push("jz_t", 7,  mk(0,0,0,0,0,0,0,3'd0,2'd0), 8'h30);
        mon_en = 1;
        start_prog(2);
        drain("progB");
        check("st_hold", hold_cnt, 3);
        check("st_writes", wr_cnt, 1);
        check("st_wr_addr", wr_addr, 8'h80);
        n = 0;
        while (!o_halted && n < 100) begin
            @(negedge clk); #2; n++;
        end
        check("halt_reached", o_halted, 1);
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            if (o_mem_req || !o_halted || o_instr_done) req_seen++;
        end
        check("halt_stays", req_seen, 0);
        check("halt_pc", o_pc, 8'h31);

        // Program C: reset while MEMRD is stalled
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h52; mem[8'h01] = 8'h90;
        start_prog(2);
        n = 0;
        while (!(o_mem_req && o_mem_addr == 8'h90 && !i_mem_ready) && n < 100) begin
            @(negedge clk); #2; n++;
        end
        check("memrd_reached", n < 100, 1);
        reset = 1'b1;
        #1;
        check("midrst_req", o_mem_req, 0);
        check("midrst_addr", o_mem_addr, 8'h00);
        check("midrst_pc", o_pc, 8'h00);
        check("midrst_rl", o_reg_load, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #2;
        check("refetch_req", o_mem_req, 1);
        check("refetch_addr", o_mem_addr, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
